// File: rtl/cpu_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam int REG_ADDR_W = 4;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 5;

endpackage

// File: rtl/ldm_stm_seq_reglist_scan.sv
// Combinational register-list scanner: lowest set bit at or above a start
// index, whether that bit is the highest one set, and the list popcount.
module reglist_scan
    import cpu_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic [NREGS-1:0]      list,
    input  logic [CNT_W-1:0]      from,
    output logic [REG_ADDR_W-1:0] idx,
    output logic                  last,
    output logic [CNT_W-1:0]      count
);

    logic found;

    // Single pass: first hit becomes idx, any later hit clears last.
    always_comb begin
        found = 1'b0;
        idx   = {REG_ADDR_W{1'b0}};
        last  = 1'b1;
        count = {CNT_W{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            if (list[i]) begin
                count = count + CNT_W'(1);
            end else begin
                count = count;
            end
            if (list[i] && (CNT_W'(i) >= from)) begin
                if (!found) begin
                    found = 1'b1;
                    idx   = REG_ADDR_W'(i);
                end else begin
                    last  = 1'b0;
                end
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// Multi-cycle LDM/STM sequencer: walks the register list in ascending order,
// one memory handshake per word, with optional base-register writeback.
module ldm_stm_seq
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_load,
    input  logic [NREGS-1:0]      reg_list,
    input  logic [REG_ADDR_W-1:0] base_reg,
    input  logic [DATA_W-1:0]     base_val,
    input  logic                  up,
    input  logic                  pre,
    input  logic                  wback,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0]     rf_rd_data,
    output logic                  rf_w_en,
    output logic [REG_ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0]     rf_w_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [DATA_W-1:0] WORD_INC = DATA_W'(WORD_BYTES);

    seq_state_e            state_r, state_n;
    logic                  is_load_r;
    logic                  wback_r;
    logic                  last_r;
    logic [NREGS-1:0]      list_r;
    logic [REG_ADDR_W-1:0] base_reg_r;
    logic [REG_ADDR_W-1:0] cur_r;
    logic [DATA_W-1:0]     addr_r;
    logic [DATA_W-1:0]     final_r;

    logic [NREGS-1:0]      scan_list_s;
    logic [CNT_W-1:0]      scan_from_s;
    logic [REG_ADDR_W-1:0] scan_idx_s;
    logic                  scan_last_s;
    logic [CNT_W-1:0]      scan_count_s;
    logic [DATA_W-1:0]     four_n_s;
    logic [DATA_W-1:0]     start_addr_s;
    logic                  wb_suppress_s;

    // In IDLE the scanner looks at the incoming list; in XFER it finds the successor of cur.
    assign scan_list_s = (state_r == IDLE) ? reg_list : list_r;
    assign scan_from_s = (state_r == IDLE) ? {CNT_W{1'b0}}
                                           : ({1'b0, cur_r} + CNT_W'(1));

    reglist_scan #(.NREGS(NREGS)) u_scan (
        .list  (scan_list_s),
        .from  (scan_from_s),
        .idx   (scan_idx_s),
        .last  (scan_last_s),
        .count (scan_count_s)
    );

    assign four_n_s      = {{(DATA_W-CNT_W-2){1'b0}}, scan_count_s, 2'b00};
    assign wb_suppress_s = is_load_r & list_r[base_reg_r];
    assign mem_wdata     = rf_rd_data;

    // Start address from the P/U addressing mode, all arithmetic mod 2^DATA_W.
    always_comb begin
        start_addr_s = base_val;
        case ({pre, up})
            2'b01:   start_addr_s = base_val;
            2'b11:   start_addr_s = base_val + WORD_INC;
            2'b00:   start_addr_s = base_val - four_n_s + WORD_INC;
            2'b10:   start_addr_s = base_val - four_n_s;
            default: start_addr_s = base_val;
        endcase
    end

    // State register plus command latch and per-word address/cursor advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            is_load_r  <= 1'b0;
            wback_r    <= 1'b0;
            last_r     <= 1'b0;
            list_r     <= {NREGS{1'b0}};
            base_reg_r <= {REG_ADDR_W{1'b0}};
            cur_r      <= {REG_ADDR_W{1'b0}};
            addr_r     <= {DATA_W{1'b0}};
            final_r    <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_n;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        is_load_r  <= is_load;
                        wback_r    <= wback;
                        list_r     <= reg_list;
                        base_reg_r <= base_reg;
                        cur_r      <= scan_idx_s;
                        last_r     <= scan_last_s;
                        addr_r     <= start_addr_s;
                        final_r    <= up ? (base_val + four_n_s) : (base_val - four_n_s);
                    end
                end
                XFER: begin
                    if (mem_ready) begin
                        addr_r <= addr_r + WORD_INC;
                        cur_r  <= scan_idx_s;
                        last_r <= scan_last_s;
                    end
                end
                default: begin
                    addr_r <= addr_r;
                end
            endcase
        end
    end

    // Next-state and output decode; everything is 0 in IDLE.
    always_comb begin
        state_n    = state_r;
        busy       = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {DATA_W{1'b0}};
        rf_rd_addr = {REG_ADDR_W{1'b0}};
        rf_w_en    = 1'b0;
        rf_w_addr  = {REG_ADDR_W{1'b0}};
        rf_w_data  = {DATA_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n = (scan_count_s == {CNT_W{1'b0}}) ? DONE : XFER;
                end else begin
                    state_n = IDLE;
                end
            end
            XFER: begin
                busy       = 1'b1;
                mem_req    = 1'b1;
                mem_we     = ~is_load_r;
                mem_addr   = addr_r;
                rf_rd_addr = cur_r;
                if (mem_ready) begin
                    rf_w_en   = is_load_r;
                    rf_w_addr = is_load_r ? cur_r : {REG_ADDR_W{1'b0}};
                    rf_w_data = is_load_r ? mem_rdata : {DATA_W{1'b0}};
                    if (last_r) begin
                        state_n = wback_r ? WB : DONE;
                    end else begin
                        state_n = XFER;
                    end
                end else begin
                    state_n = XFER;
                end
            end
            WB: begin
                // A loaded base register keeps its loaded value.
                busy      = 1'b1;
                rf_w_en   = ~wb_suppress_s;
                rf_w_addr = base_reg_r;
                rf_w_data = final_r;
                state_n   = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
